// File: rtl/dac_spi_writer.sv
// Dual-channel SPI DAC writer: shifts an A frame and a B frame, then pulses ldac_n
// so both channels update together. Every output pin comes straight from a flop.
module dac_spi_writer #(
    parameter int unsigned CLK_DIV = 2,
    parameter logic [3:0]  HDR_A   = 4'b0011,
    parameter logic [3:0]  HDR_B   = 4'b1011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] word_a,
    input  logic [11:0] word_b,
    output logic        busy,
    output logic        done,
    output logic        cs_n,
    output logic        sclk,
    output logic        sdi,
    output logic        ldac_n
);

    typedef enum logic [2:0] {
        StIdle, StFrameA, StGapA, StFrameB, StGapB, StLdac
    } state_t;

    localparam logic [7:0] PhaseMax = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic [11:0] word_b_q, word_b_d;
    logic        busy_q, busy_d, done_q, done_d, cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d, sdi_q, sdi_d, ldac_n_q, ldac_n_d;
    logic        phase_last;

    assign phase_last = (phase_q == PhaseMax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            word_b_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            sdi_q    <= 1'b0;
            ldac_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            word_b_q <= word_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            sdi_q    <= sdi_d;
            ldac_n_q <= ldac_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        word_b_d = word_b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        sdi_d    = sdi_q;
        ldac_n_d = ldac_n_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StFrameA;
                    shift_d  = {HDR_A, word_a};
                    sdi_d    = HDR_A[3];
                    word_b_d = word_b;
                    cs_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    phase_d  = '0;
                    bit_d    = 4'd15;
                end
            end
            StFrameA, StFrameB: begin
                if (!phase_last) begin
                    phase_d = phase_q + 8'd1;
                end else begin
                    phase_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling sclk is the only point where sdi may move.
                        sclk_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            cs_n_d  = 1'b1;
                            sdi_d   = 1'b0;
                            state_d = (state_q == StFrameA) ? StGapA : StGapB;
                        end else begin
                            bit_d   = bit_q - 4'd1;
                            shift_d = {shift_q[14:0], 1'b0};
                            sdi_d   = shift_q[14];
                        end
                    end
                end
            end
            StGapA: begin
                if (!phase_last) begin
                    phase_d = phase_q + 8'd1;
                end else begin
                    phase_d = '0;
                    state_d = StFrameB;
                    shift_d = {HDR_B, word_b_q};
                    sdi_d   = HDR_B[3];
                    cs_n_d  = 1'b0;
                    bit_d   = 4'd15;
                end
            end
            StGapB: begin
                if (!phase_last) begin
                    phase_d = phase_q + 8'd1;
                end else begin
                    phase_d  = '0;
                    state_d  = StLdac;
                    ldac_n_d = 1'b0;
                end
            end
            StLdac: begin
                if (!phase_last) begin
                    phase_d = phase_q + 8'd1;
                end else begin
                    phase_d  = '0;
                    state_d  = StIdle;
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign cs_n   = cs_n_q;
    assign sclk   = sclk_q;
    assign sdi    = sdi_q;
    assign ldac_n = ldac_n_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench for dac_spi_writer: a CLK_DIV=2 instance and a CLK_DIV=1 instance,
// each watched by an SPI frame monitor.
module tb_dac_spi_writer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [11:0] wa0 = '0, wb0 = '0, wa1 = '0, wb1 = '0;
    logic busy0, done0, cs_n0, sclk0, sdi0, ldac_n0;
    logic busy1, done1, cs_n1, sclk1, sdi1, ldac_n1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_writer #(.CLK_DIV(2)) u0 (
        .clk(clk), .reset(reset), .start(start0), .word_a(wa0), .word_b(wb0),
        .busy(busy0), .done(done0), .cs_n(cs_n0), .sclk(sclk0), .sdi(sdi0), .ldac_n(ldac_n0)
    );

    dac_spi_writer #(.CLK_DIV(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .word_a(wa1), .word_b(wb1),
        .busy(busy1), .done(done1), .cs_n(cs_n1), .sclk(sclk1), .sdi(sdi1), .ldac_n(ldac_n1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Monitor state, sampled on the falling clk edge.
    logic [15:0] sh0 = '0, sh1 = '0;
    logic [15:0] frames0[$], frames1[$];
    int nb0 = 0, nb1 = 0, rises0 = 0, rises1 = 0, gaperr0 = 0, gaperr1 = 0;
    int last0 = 0, last1 = 0, ldlow0 = 0, ldpulse0 = 0, ldlow1 = 0, ldpulse1 = 0;
    logic p_sclk0 = 1'b0, p_cs0 = 1'b1, p_ld0 = 1'b1, p_sdi0 = 1'b0;
    logic p_sclk1 = 1'b0, p_cs1 = 1'b1, p_ld1 = 1'b1, p_sdi1 = 1'b0;

    always @(negedge clk) begin
        if (!cs_n0 && p_cs0) nb0 = 0;
        if (sclk0 && !p_sclk0) begin
            rises0++;
            if (!cs_n0) begin
                sh0 = {sh0[14:0], sdi0};
                nb0++;
                if (nb0 > 1 && cyc - last0 != 4) gaperr0++;
                last0 = cyc;
            end
        end
        if (cs_n0 && !p_cs0) begin
            if (nb0 == 16) frames0.push_back(sh0);
            nb0 = 0;
        end
        if (!ldac_n0) ldlow0++;
        if (!ldac_n0 && p_ld0) ldpulse0++;
        if (sclk0) chk1("sdi_stable_d2", sdi0, p_sdi0);
        p_sclk0 = sclk0; p_cs0 = cs_n0; p_ld0 = ldac_n0; p_sdi0 = sdi0;

        if (!cs_n1 && p_cs1) nb1 = 0;
        if (sclk1 && !p_sclk1) begin
            rises1++;
            if (!cs_n1) begin
                sh1 = {sh1[14:0], sdi1};
                nb1++;
                if (nb1 > 1 && cyc - last1 != 2) gaperr1++;
                last1 = cyc;
            end
        end
        if (cs_n1 && !p_cs1) begin
            if (nb1 == 16) frames1.push_back(sh1);
            nb1 = 0;
        end
        if (!ldac_n1) ldlow1++;
        if (!ldac_n1 && p_ld1) ldpulse1++;
        if (sclk1) chk1("sdi_stable_d1", sdi1, p_sdi1);
        p_sclk1 = sclk1; p_cs1 = cs_n1; p_ld1 = ldac_n1; p_sdi1 = sdi1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Counts cycles after the acceptance sample until done; 1000-cycle bound.
    task automatic wait_done(input int sel, output int n);
        n = 0;
        while (((sel == 0) ? done0 : done1) !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("done_seen", ((sel == 0) ? {31'b0, done0} : {31'b0, done1}), 32'd1);
    endtask

    task automatic chk_frames0(input logic [15:0] fa, input logic [15:0] fb);
        chk("frames0_count", frames0.size(), 2);
        if (frames0.size() > 0) chk("frame0_a", 32'(frames0.pop_front()), 32'(fa));
        if (frames0.size() > 0) chk("frame0_b", 32'(frames0.pop_front()), 32'(fb));
        frames0.delete();
    endtask

    initial begin
        int n;
        logic [11:0] ra, rb;

        // Reset state
        step();
        step();
        chk1("rst_cs_n", cs_n0, 1'b1);
        chk1("rst_sclk", sclk0, 1'b0);
        chk1("rst_sdi", sdi0, 1'b0);
        chk1("rst_ldac_n", ldac_n0, 1'b1);
        chk1("rst_busy", busy0, 1'b0);
        chk1("rst_done", done0, 1'b0);
        reset = 1'b0;

        // Nominal transfer, with ignored re-starts and a late word_a change
        wa0 = 12'h09D; wb0 = 12'h092; start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk1("t1_cs_n_cycle1", cs_n0, 1'b0);
        chk1("t1_busy_cycle1", busy0, 1'b1);
        n = 0;
        while (done0 !== 1'b1 && n < 1000) begin
            start0 = (n == 9 || n == 99);
            if (n == 4) wa0 = 12'hFFF;
            step();
            n++;
        end
        start0 = 1'b0;
        chk("t1_done_cycle", n + 1, 135);
        chk1("t1_busy_at_done", busy0, 1'b0);
        chk_frames0(16'h309D, 16'hB092);
        chk("t1_ldac_pulses", ldpulse0, 1);
        chk("t1_ldac_width", ldlow0, 2);
        chk("t1_sclk_rises", rises0, 32);

        // Back-to-back: start held on the done cycle
        wa0 = 12'h123; wb0 = 12'hABC; start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk1("b2b_done_single", done0, 1'b0);
        chk1("b2b_cs_n_falls", cs_n0, 1'b0);
        wait_done(0, n);
        chk("b2b_done_cycle", n + 1, 135);
        step();
        chk1("b2b_done_single2", done0, 1'b0);
        chk_frames0(16'h3123, 16'hBABC);
        chk("b2b_ldac_pulses", ldpulse0, 2);
        chk("b2b_sclk_rises", rises0, 64);

        // Reset mid FRAME_A at cycle 40
        wa0 = 12'h555; wb0 = 12'h0AA; start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (39) step();
        reset = 1'b1;
        #1;
        chk1("rst40_cs_n", cs_n0, 1'b1);
        chk1("rst40_sclk", sclk0, 1'b0);
        chk1("rst40_busy", busy0, 1'b0);
        step();
        step();
        reset = 1'b0;
        chk("rst40_no_ldac", ldpulse0, 2);
        chk("rst40_no_frame", frames0.size(), 0);
        wa0 = 12'h7E1; wb0 = 12'h18C; start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk1("rst40_restart_cs_n", cs_n0, 1'b0);
        wait_done(0, n);
        chk("rst40_done_cycle", n + 1, 135);
        chk_frames0(16'h37E1, 16'hB18C);
        chk("rst40_ldac_pulses", ldpulse0, 3);
        chk("d2_sclk_spacing", gaperr0, 0);

        // CLK_DIV = 1
        wa1 = 12'hFFF; wb1 = 12'h000; start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_done(1, n);
        chk("d1_done_cycle", n + 1, 68);
        chk("d1_frames_count", frames1.size(), 2);
        if (frames1.size() > 0) chk("d1_frame_a", 32'(frames1.pop_front()), 32'h3FFF);
        if (frames1.size() > 0) chk("d1_frame_b", 32'(frames1.pop_front()), 32'hB000);
        frames1.delete();
        chk("d1_sclk_rises", rises1, 32);
        chk("d1_sclk_spacing", gaperr1, 0);

        // Randomized words; sdi stability is checked continuously by the monitor
        for (int i = 0; i < 1000; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            wa1 = ra; wb1 = rb; start1 = 1'b1;
            step();
            start1 = 1'b0;
            wait_done(1, n);
            chk("rnd_frames_count", frames1.size(), 2);
            if (frames1.size() > 0) chk("rnd_frame_a", 32'(frames1.pop_front()), {16'h0, 4'h3, ra});
            if (frames1.size() > 0) chk("rnd_frame_b", 32'(frames1.pop_front()), {16'h0, 4'hB, rb});
            frames1.delete();
        end
        chk("rnd_sclk_rises", rises1, 32 * 1001);
        chk("rnd_ldac_pulses", ldpulse1, 1001);
        chk("rnd_sclk_spacing", gaperr1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
